// File: rtl/fetch_unit_if.sv
// Bundles the fetch unit's redirect, imem request/response and decode dequeue signals.
// The master modport is the fetch unit's view; the slave modport is the surrounding system's view.
interface fetch_unit_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_rdata;
    logic        deq_valid;
    logic        deq_ready;
    logic [31:0] deq_pc;
    logic [31:0] deq_pc_next;
    logic [31:0] deq_inst;

    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_rdata, deq_ready,
        output imem_req_valid, imem_addr, deq_valid, deq_pc, deq_pc_next, deq_inst
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_rdata, deq_ready,
        input  imem_req_valid, imem_addr, deq_valid, deq_pc, deq_pc_next, deq_inst
    );
endinterface

// File: rtl/fetch_unit.sv
// Fetch front end: PC generator, in-order imem handshake with credit-limited requests, and a
// DEPTH-entry instruction queue for decode. Redirects flush the queue and drop stale responses.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h6000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] C_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] C_ZERO = CW'(1'b0);
    localparam logic [AW:0]   A_ONE  = (AW + 1)'(1'b1);

    logic [31:0]   r_pc;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_occ;
    logic [CW-1:0] r_out;
    logic [CW-1:0] r_drop;
    logic [AW:0]   r_head;
    logic [AW:0]   r_tail;
    logic [31:0]   r_q_pc   [DEPTH];
    logic [31:0]   r_q_next [DEPTH];
    logic [31:0]   r_q_inst [DEPTH];

    logic [CW+1:0] w_inflight;
    logic [CW:0]   w_stale_sum;
    logic [CW-1:0] w_drop_redir;
    logic [31:0]   w_redirect_pc;
    logic          w_req_valid;
    logic          w_req_fire;
    logic          w_resp_ok;
    logic          w_resp_drop;
    logic          w_deq_valid;
    logic          w_deq_fire;

    // Every request ever issued holds a credit until it is dequeued or its stale response is dropped.
    assign w_inflight    = (CW + 2)'(r_occ) + (CW + 2)'(r_out) + (CW + 2)'(r_drop);
    assign w_stale_sum   = {1'b0, r_drop} + {1'b0, r_out};
    assign w_drop_redir  = (bus.imem_resp_valid && (w_stale_sum != {(CW + 1){1'b0}}))
                         ? CW'(w_stale_sum - {{CW{1'b0}}, 1'b1}) : CW'(w_stale_sum);
    assign w_redirect_pc = {bus.redirect_pc[31:2], 2'b00};

    assign w_req_valid = ~rst & ~bus.redirect_valid & (w_inflight < (CW + 2)'(DEPTH));
    assign w_req_fire  = w_req_valid & bus.imem_req_ready;
    assign w_resp_ok   = bus.imem_resp_valid & ~bus.redirect_valid & (r_drop == C_ZERO) & (r_out != C_ZERO);
    assign w_resp_drop = bus.imem_resp_valid & ~bus.redirect_valid & (r_drop != C_ZERO);
    assign w_deq_valid = ~rst & ~bus.redirect_valid & (r_occ != C_ZERO);
    assign w_deq_fire  = w_deq_valid & bus.deq_ready;

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_addr      = r_pc;
    assign bus.deq_valid      = w_deq_valid;
    assign bus.deq_pc         = r_q_pc[r_head[AW-1:0]];
    assign bus.deq_pc_next    = r_q_next[r_head[AW-1:0]];
    assign bus.deq_inst       = r_q_inst[r_head[AW-1:0]];

    // PC, credit counters and queue pointers; a redirect overrides every other update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_resp_pc <= RESET_PC;
            r_occ     <= C_ZERO;
            r_out     <= C_ZERO;
            r_drop    <= C_ZERO;
            r_head    <= {(AW + 1){1'b0}};
            r_tail    <= {(AW + 1){1'b0}};
        end else if (bus.redirect_valid) begin
            r_pc      <= w_redirect_pc;
            r_resp_pc <= w_redirect_pc;
            r_occ     <= C_ZERO;
            r_out     <= C_ZERO;
            r_drop    <= w_drop_redir;
            r_head    <= r_tail;
        end else begin
            if (w_req_fire) begin
                r_pc <= r_pc + 32'd4;
            end
            if (w_resp_drop) begin
                r_drop <= r_drop - C_ONE;
            end
            if (w_resp_ok) begin
                r_resp_pc <= r_resp_pc + 32'd4;
                r_tail    <= r_tail + A_ONE;
            end
            if (w_deq_fire) begin
                r_head <= r_head + A_ONE;
            end
            r_out <= r_out + (w_req_fire ? C_ONE : C_ZERO) - (w_resp_ok ? C_ONE : C_ZERO);
            r_occ <= r_occ + (w_resp_ok ? C_ONE : C_ZERO) - (w_deq_fire ? C_ONE : C_ZERO);
        end
    end

    // Queue storage, written at the tail by accepted responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q_pc[i]   <= 32'd0;
                r_q_next[i] <= 32'd0;
                r_q_inst[i] <= 32'd0;
            end
        end else if (w_resp_ok) begin
            r_q_pc[r_tail[AW-1:0]]   <= r_resp_pc;
            r_q_next[r_tail[AW-1:0]] <= r_resp_pc + 32'd4;
            r_q_inst[r_tail[AW-1:0]] <= bus.imem_resp_rdata;
        end
    end

    fetch_unit_chk #(.CW(CW), .DEPTH(DEPTH)) u_chk (
        .clk          (clk),
        .rst          (rst),
        .i_resp_valid (bus.imem_resp_valid),
        .i_out        (r_out),
        .i_drop       (r_drop),
        .i_inflight   (w_inflight)
    );
endmodule

// Protocol checks: no response without a matching request, and credits never exceed DEPTH.
module fetch_unit_chk #(
    parameter int CW    = 3,
    parameter int DEPTH = 4
) (
    input logic          clk,
    input logic          rst,
    input logic          i_resp_valid,
    input logic [CW-1:0] i_out,
    input logic [CW-1:0] i_drop,
    input logic [CW+1:0] i_inflight
);
    a_no_orphan_resp: assert property (@(posedge clk) disable iff (rst)
        i_resp_valid |-> ((i_out != {CW{1'b0}}) || (i_drop != {CW{1'b0}})));

    a_credit_bound: assert property (@(posedge clk) disable iff (rst)
        i_inflight <= (CW + 2)'(DEPTH));
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: fixed-latency in-order memory model, hand-computed addresses,
// queue contents, credit limits, redirect/drop behaviour, PC wrap and asynchronous reset.
module tb_fetch_unit;
    localparam logic [31:0] KEY = 32'h1357_9BDF;

    logic clk;
    logic rst;
    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(32'h6000_0000), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          lat = 1;
    int          n_req = 0;
    int          n_deq = 0;
    logic        t_redir = 1'b0;
    logic [31:0] t_redir_pc = 32'd0;
    logic        t_req_ready = 1'b1;
    logic        t_deq_ready = 1'b1;
    logic        s_req_valid;
    logic        s_deq_valid;
    logic [31:0] exp_req_addr;
    logic [31:0] exp_deq_pc;
    logic [31:0] first_next;
    logic [31:0] pend_addr [$];
    int          pend_due  [$];
    logic [31:0] req_log   [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pend_addr.delete();
        pend_due.delete();
        req_log.delete();
        cyc          = 0;
        n_req        = 0;
        n_deq        = 0;
        exp_req_addr = 32'h6000_0000;
        exp_deq_pc   = 32'h6000_0000;
    endtask

    // One clock cycle: called at a falling edge, drives inputs, samples, returns at the next falling edge.
    task automatic cycle();
        bus.redirect_valid = t_redir;
        bus.redirect_pc    = t_redir_pc;
        bus.imem_req_ready = t_req_ready;
        bus.deq_ready      = t_deq_ready;
        if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_rdata = pend_addr[0] ^ KEY;
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_rdata = 32'hDEAD_BEEF;
        end
        #1;
        s_req_valid = bus.imem_req_valid;
        s_deq_valid = bus.deq_valid;
        if (t_redir) begin
            chk("redir_req_valid", 32'(bus.imem_req_valid), 32'd0);
            chk("redir_deq_valid", 32'(bus.deq_valid), 32'd0);
        end
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            chk("req_addr", bus.imem_addr, exp_req_addr);
            pend_addr.push_back(bus.imem_addr);
            pend_due.push_back(cyc + lat);
            req_log.push_back(bus.imem_addr);
            exp_req_addr = exp_req_addr + 32'd4;
            n_req++;
        end
        if (bus.deq_valid && bus.deq_ready) begin
            chk("deq_pc", bus.deq_pc, exp_deq_pc);
            chk("deq_pc_next", bus.deq_pc_next, exp_deq_pc + 32'd4);
            chk("deq_inst", bus.deq_inst, exp_deq_pc ^ KEY);
            if (n_deq == 0) first_next = bus.deq_pc_next;
            exp_deq_pc = exp_deq_pc + 32'd4;
            n_deq++;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic redirect_to(input logic [31:0] pc, input logic [31:0] exp_pc);
        t_redir    = 1'b1;
        t_redir_pc = pc;
        cycle();
        t_redir      = 1'b0;
        exp_req_addr = exp_pc;
        exp_deq_pc   = exp_pc;
        n_req        = 0;
        n_deq        = 0;
        req_log.delete();
    endtask

    initial begin
        rst                 = 1'b1;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = 32'd0;
        bus.imem_req_ready  = 1'b1;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_rdata = 32'd0;
        bus.deq_ready       = 1'b1;
        #1;
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rst_deq_valid", 32'(bus.deq_valid), 32'd0);
        chk("rst_addr", bus.imem_addr, 32'h6000_0000);

        // Streaming with a one-cycle memory and an always-ready decoder.
        do_reset();
        lat = 1; t_req_ready = 1'b1; t_deq_ready = 1'b1;
        repeat (12) cycle();
        chk("t1_nreq", 32'(n_req), 32'd12);
        chk("t1_ndeq", 32'(n_deq), 32'd10);

        // Decoder stalled: fetch stops after DEPTH requests, then one request per dequeue.
        do_reset();
        lat = 1; t_deq_ready = 1'b0;
        repeat (8) cycle();
        chk("t2_nreq", 32'(n_req), 32'd4);
        chk("t2_req_valid", 32'(s_req_valid), 32'd0);
        chk("t2_deq_valid", 32'(s_deq_valid), 32'd1);
        chk("t2_occ", 32'(dut.r_occ), 32'd4);
        t_deq_ready = 1'b1;
        cycle();
        chk("t2_req_valid_deq", 32'(s_req_valid), 32'd0);
        t_deq_ready = 1'b0;
        repeat (5) cycle();
        chk("t2_nreq_after", 32'(n_req), 32'd5);
        chk("t2_ndeq_after", 32'(n_deq), 32'd1);
        t_deq_ready = 1'b1;
        repeat (12) cycle();

        // Redirect with three requests outstanding on a four-cycle memory.
        do_reset();
        lat = 4; t_deq_ready = 1'b1;
        for (int i = 0; i < 10 && n_req < 3; i++) cycle();
        chk("t3_nreq", 32'(n_req), 32'd3);
        redirect_to(32'h6000_0103, 32'h6000_0100);
        chk("t3_drop", 32'(dut.r_drop), 32'd3);
        repeat (20) cycle();
        chk("t3_deq_seen", 32'(n_deq != 0), 32'd1);

        // Redirect coincident with a response while all credits are in use.
        do_reset();
        lat = 5; t_deq_ready = 1'b0;
        repeat (6) cycle();
        chk("t4_nreq", 32'(n_req), 32'd4);
        redirect_to(32'h6000_0200, 32'h6000_0200);
        chk("t4_drop", 32'(dut.r_drop), 32'd2);
        cycle();
        chk("t4_deq_valid_next", 32'(s_deq_valid), 32'd0);
        t_deq_ready = 1'b1;
        repeat (25) cycle();
        chk("t4_deq_seen", 32'(n_deq != 0), 32'd1);

        // Redirect to the top of the address space: addresses and pc_next wrap to zero.
        do_reset();
        lat = 1; t_deq_ready = 1'b1;
        repeat (3) cycle();
        redirect_to(32'hFFFF_FFFC, 32'hFFFF_FFFC);
        repeat (6) cycle();
        chk("t5_nreq", 32'(n_req >= 2), 32'd1);
        chk("t5_addr0", req_log[0], 32'hFFFF_FFFC);
        chk("t5_addr1", req_log[1], 32'h0000_0000);
        chk("t5_first_next", first_next, 32'h0000_0000);

        // Asynchronous reset between clock edges in the middle of a stream.
        do_reset();
        lat = 1; t_deq_ready = 1'b1;
        repeat (7) cycle();
        #2;
        rst = 1'b1;
        #1;
        chk("t6_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("t6_deq_valid", 32'(bus.deq_valid), 32'd0);
        chk("t6_addr", bus.imem_addr, 32'h6000_0000);
        @(negedge clk);
        do_reset();
        repeat (4) cycle();
        chk("t6_nreq", 32'(n_req), 32'd4);
        chk("t6_first_addr", req_log[0], 32'h6000_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
